// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM on-time timer: channel state encoding and
// default counter widths used by the timer channels and the multi-channel top.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2,
      ST_HOLD  = 2'd3
   } ton_state_e;

   localparam int DEF_W  = 21;
   localparam int DEF_BW = 8;

endpackage

// File: rtl/ton_channel.sv
// One on-time timer channel: a set rising edge opens an interval that ends on
// the programmed maximum on-time or on a trip after blanking, emitting a
// one-cycle reset_pwm, then enforces a minimum off-time before re-arming.
module ton_channel
   import pwm_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int BW = DEF_BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          set,
   input  logic          trip,
   input  logic [W-1:0]  ton_time,
   input  logic [BW-1:0] blank_time,
   input  logic [W-1:0]  toff_min,
   output logic          reset_pwm,
   output logic          busy,
   output logic          trip_flag,
   output logic [W-1:0]  ton_meas,
   output logic          meas_valid
);

   ton_state_e    state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic          set_dly_q, set_dly_d;
   logic [W-1:0]  ton_l_q, ton_l_d;
   logic [BW-1:0] blank_l_q, blank_l_d;
   logic [W-1:0]  toff_l_q, toff_l_d;
   logic          reset_pwm_q, reset_pwm_d;
   logic          meas_valid_q, meas_valid_d;
   logic          trip_flag_q, trip_flag_d;
   logic [W-1:0]  ton_meas_q, ton_meas_d;

   logic          set_pos;
   logic          end_to;
   logic          end_tr;
   logic [W-1:0]  blank_last;
   logic [W-1:0]  toff_last;

   assign set_pos    = set & ~set_dly_q;
   assign end_to     = (cnt_q == ton_l_q);
   assign end_tr     = trip & (state_q == ST_ON);
   // Last counter value of the blanking / off-time windows; only compared in
   // states that are entered with a non-zero window, so no underflow matters.
   assign blank_last = W'(blank_l_q) - W'(1);
   assign toff_last  = toff_l_q - W'(1);

   // Next-state, counter, latched-program and output-register logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      set_dly_d    = set;
      ton_l_d      = ton_l_q;
      blank_l_d    = blank_l_q;
      toff_l_d     = toff_l_q;
      reset_pwm_d  = 1'b0;
      meas_valid_d = 1'b0;
      trip_flag_d  = trip_flag_q;
      ton_meas_d   = ton_meas_q;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (set_pos && en) begin
               ton_l_d   = ton_time;
               blank_l_d = blank_time;
               toff_l_d  = toff_min;
               state_d   = (blank_time == '0) ? ST_ON : ST_BLANK;
            end
         end

         ST_BLANK, ST_ON: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (end_to || end_tr) begin
               reset_pwm_d  = 1'b1;
               meas_valid_d = 1'b1;
               ton_meas_d   = cnt_q;
               trip_flag_d  = end_tr;
               cnt_d        = '0;
               state_d      = (toff_l_q == '0) ? ST_IDLE : ST_HOLD;
            end else begin
               cnt_d = cnt_q + W'(1);
               if (state_q == ST_BLANK && cnt_q == blank_last) begin
                  state_d = ST_ON;
               end
            end
         end

         ST_HOLD: begin
            if (!en || cnt_q == toff_last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Channel state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         set_dly_q    <= 1'b0;
         ton_l_q      <= '0;
         blank_l_q    <= '0;
         toff_l_q     <= '0;
         reset_pwm_q  <= 1'b0;
         meas_valid_q <= 1'b0;
         trip_flag_q  <= 1'b0;
         ton_meas_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         set_dly_q    <= set_dly_d;
         ton_l_q      <= ton_l_d;
         blank_l_q    <= blank_l_d;
         toff_l_q     <= toff_l_d;
         reset_pwm_q  <= reset_pwm_d;
         meas_valid_q <= meas_valid_d;
         trip_flag_q  <= trip_flag_d;
         ton_meas_q   <= ton_meas_d;
      end
   end

   assign reset_pwm  = reset_pwm_q;
   assign meas_valid = meas_valid_q;
   assign trip_flag  = trip_flag_q;
   assign ton_meas   = ton_meas_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: rtl/ton_multi_timer.sv
// Multi-channel on-time timer: one independent ton_channel per PWM phase,
// with the packed programming and measurement buses sliced per channel.
module ton_multi_timer
   import pwm_pkg::*;
#(
   parameter int CH = 4,
   parameter int W  = DEF_W,
   parameter int BW = DEF_BW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    en,
   input  logic [CH-1:0]    set,
   input  logic [CH-1:0]    trip,
   input  logic [CH*W-1:0]  ton_time,
   input  logic [CH*BW-1:0] blank_time,
   input  logic [CH*W-1:0]  toff_min,
   output logic [CH-1:0]    reset_pwm,
   output logic [CH-1:0]    busy,
   output logic [CH-1:0]    trip_flag,
   output logic [CH*W-1:0]  ton_meas,
   output logic [CH-1:0]    meas_valid
);

   for (genvar g = 0; g < CH; g++) begin : g_ch
      ton_channel #(
         .W  (W),
         .BW (BW)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .en         (en[g]),
         .set        (set[g]),
         .trip       (trip[g]),
         .ton_time   (ton_time[g*W +: W]),
         .blank_time (blank_time[g*BW +: BW]),
         .toff_min   (toff_min[g*W +: W]),
         .reset_pwm  (reset_pwm[g]),
         .busy       (busy[g]),
         .trip_flag  (trip_flag[g]),
         .ton_meas   (ton_meas[g*W +: W]),
         .meas_valid (meas_valid[g])
      );
   end

endmodule

// File: tb/tb_ton_multi_timer.sv
// Directed bench for ton_multi_timer: inputs change and outputs are sampled
// on the falling clock edge, expected values are worked out by hand.
module tb_ton_multi_timer;

   localparam int CH = 4;
   localparam int W  = 21;
   localparam int BW = 8;

   logic             clk;
   logic             rst;
   logic [CH-1:0]    en;
   logic [CH-1:0]    set;
   logic [CH-1:0]    trip;
   logic [CH*W-1:0]  ton_time;
   logic [CH*BW-1:0] blank_time;
   logic [CH*W-1:0]  toff_min;
   logic [CH-1:0]    reset_pwm;
   logic [CH-1:0]    busy;
   logic [CH-1:0]    trip_flag;
   logic [CH*W-1:0]  ton_meas;
   logic [CH-1:0]    meas_valid;

   int checkCount;
   int passCount;

   ton_multi_timer #(
      .CH (CH),
      .W  (W),
      .BW (BW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .set        (set),
      .trip       (trip),
      .ton_time   (ton_time),
      .blank_time (blank_time),
      .toff_min   (toff_min),
      .reset_pwm  (reset_pwm),
      .busy       (busy),
      .trip_flag  (trip_flag),
      .ton_meas   (ton_meas),
      .meas_valid (meas_valid)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next falling edge, where inputs are driven and outputs read
   task automatic stepCycle();
      @(negedge clk);
   endtask

   // Program one channel's on-time, blanking and off-time
   task automatic applyStimulus(input int ch, input int ton, input int blank, input int toff);
      ton_time[ch*W +: W]    = W'(ton);
      blank_time[ch*BW +: BW] = BW'(blank);
      toff_min[ch*W +: W]    = W'(toff);
   endtask

   // Compare one observed value with its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   function automatic logic [31:0] measOf(input int ch);
      return 32'(ton_meas[ch*W +: W]);
   endfunction

   int            startCyc [CH] = '{0, 1, 2, 3};
   int            fireCyc  [CH] = '{6, 10, 6, 14};
   logic [CH-1:0] expVec;

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst        = 1'b1;
      en         = '0;
      set        = '0;
      trip       = '0;
      ton_time   = '0;
      blank_time = '0;
      toff_min   = '0;
      stepCycle();
      stepCycle();

      $display("[TB] reset state");
      checkOutput("rst_reset_pwm", 32'(reset_pwm), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_meas_valid", 32'(meas_valid), 0);
      checkOutput("rst_trip_flag", 32'(trip_flag), 0);
      checkOutput("rst_ton_meas", 32'(ton_meas != '0), 0);
      rst = 1'b0;
      en  = 4'hF;
      stepCycle();

      $display("[TB] ch0 timeout ton=10 blank=3");
      applyStimulus(0, 10, 3, 0);
      set[0] = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         stepCycle();
         checkOutput("t1_reset_pwm", 32'(reset_pwm), (i == 12) ? 32'h1 : 32'h0);
         if (i == 1) checkOutput("t1_busy_start", 32'(busy), 32'h1);
         if (i == 12) begin
            checkOutput("t1_meas_valid", 32'(meas_valid), 32'h1);
            checkOutput("t1_ton_meas", measOf(0), 10);
            checkOutput("t1_trip_flag", 32'(trip_flag[0]), 0);
            checkOutput("t1_busy_end", 32'(busy), 0);
         end
      end
      set[0] = 1'b0;

      $display("[TB] ch1 trip in blank ignored, trip in on");
      applyStimulus(1, 100, 4, 0);
      set[1] = 1'b1;
      stepCycle();
      stepCycle();
      stepCycle();
      trip[1] = 1'b1;
      stepCycle();
      checkOutput("t2_blank_trip_ignored", 32'(reset_pwm), 0);
      checkOutput("t2_busy", 32'(busy), 32'h2);
      trip[1] = 1'b0;
      stepCycle();
      stepCycle();
      trip[1] = 1'b1;
      stepCycle();
      checkOutput("t2_trip_reset_pwm", 32'(reset_pwm), 32'h2);
      checkOutput("t2_meas_valid", 32'(meas_valid), 32'h2);
      checkOutput("t2_ton_meas", measOf(1), 5);
      checkOutput("t2_trip_flag", 32'(trip_flag[1]), 1);
      checkOutput("t2_ch0_meas_kept", measOf(0), 10);
      trip[1] = 1'b0;
      set[1]  = 1'b0;
      stepCycle();
      checkOutput("t2_pulse_one_cycle", 32'(reset_pwm), 0);
      checkOutput("t2_idle", 32'(busy), 0);

      $display("[TB] ch2 zero on-time, zero blank");
      applyStimulus(2, 0, 0, 0);
      set[2] = 1'b1;
      stepCycle();
      checkOutput("t3_busy", 32'(busy), 32'h4);
      checkOutput("t3_no_early_reset", 32'(reset_pwm), 0);
      stepCycle();
      checkOutput("t3_reset_pwm", 32'(reset_pwm), 32'h4);
      checkOutput("t3_ton_meas", measOf(2), 0);
      checkOutput("t3_trip_flag_to", 32'(trip_flag[2]), 0);
      set[2] = 1'b0;
      stepCycle();
      trip[2] = 1'b1;
      set[2]  = 1'b1;
      stepCycle();
      checkOutput("t3_idle_trip_ignored", 32'(reset_pwm), 0);
      stepCycle();
      checkOutput("t3_both_reset_pwm", 32'(reset_pwm), 32'h4);
      checkOutput("t3_trip_wins", 32'(trip_flag[2]), 1);
      trip[2] = 1'b0;
      set[2]  = 1'b0;
      stepCycle();

      $display("[TB] ch3 minimum off-time 6");
      applyStimulus(3, 5, 2, 6);
      set[3] = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         stepCycle();
         checkOutput("t4_reset_pwm", 32'(reset_pwm), (i == 7) ? 32'h8 : 32'h0);
         checkOutput("t4_busy", 32'(busy[3]), (i <= 12) ? 32'h1 : 32'h0);
         if (i == 7)  set[3] = 1'b0;
         if (i == 8)  set[3] = 1'b1;
         if (i == 10) set[3] = 1'b0;
         if (i == 11) set[3] = 1'b1;
         if (i == 12) set[3] = 1'b0;
      end
      set[3] = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         stepCycle();
         checkOutput("t4_restart_busy", 32'(busy[3]), 1);
         checkOutput("t4_restart_reset_pwm", 32'(reset_pwm), (i == 7) ? 32'h8 : 32'h0);
      end
      checkOutput("t4_restart_meas", measOf(3), 5);
      checkOutput("t4_restart_flag", 32'(trip_flag[3]), 0);
      set[3] = 1'b0;
      repeat (7) stepCycle();
      checkOutput("t4_hold_done", 32'(busy), 0);

      $display("[TB] reset mid-interval");
      applyStimulus(0, 50, 2, 0);
      set[0] = 1'b1;
      repeat (8) stepCycle();
      checkOutput("t5_running", 32'(busy), 32'h1);
      rst    = 1'b1;
      set[0] = 1'b0;
      stepCycle();
      rst = 1'b0;
      checkOutput("t5_rst_busy", 32'(busy), 0);
      checkOutput("t5_rst_reset_pwm", 32'(reset_pwm), 0);
      checkOutput("t5_rst_meas0", measOf(0), 0);
      checkOutput("t5_rst_meas3", measOf(3), 0);
      checkOutput("t5_rst_trip_flag", 32'(trip_flag), 0);

      $display("[TB] enable dropped mid-interval");
      applyStimulus(1, 3, 0, 0);
      set[1] = 1'b1;
      repeat (5) stepCycle();
      checkOutput("t5_short_reset_pwm", 32'(reset_pwm), 32'h2);
      checkOutput("t5_short_meas", measOf(1), 3);
      set[1] = 1'b0;
      applyStimulus(1, 50, 2, 0);
      stepCycle();
      set[1] = 1'b1;
      repeat (8) stepCycle();
      checkOutput("t5_en_running", 32'(busy), 32'h2);
      en[1] = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         stepCycle();
         checkOutput("t5_en_busy", 32'(busy), 0);
         checkOutput("t5_en_reset_pwm", 32'(reset_pwm), 0);
         checkOutput("t5_en_meas_valid", 32'(meas_valid), 0);
      end
      checkOutput("t5_en_meas_kept", measOf(1), 3);
      en[1]  = 1'b1;
      set[1] = 1'b0;
      stepCycle();

      $display("[TB] four staggered channels");
      applyStimulus(0, 4, 1, 0);
      applyStimulus(1, 7, 1, 0);
      applyStimulus(2, 2, 1, 0);
      applyStimulus(3, 9, 1, 0);
      stepCycle();
      for (int i = 0; i < 16; i++) begin
         for (int c = 0; c < CH; c++) begin
            if (i == startCyc[c]) set[c] = 1'b1;
         end
         if (i == 2) ton_time[0 +: W] = W'(1);
         stepCycle();
         expVec = '0;
         for (int c = 0; c < CH; c++) begin
            if (i + 1 == fireCyc[c]) expVec[c] = 1'b1;
         end
         checkOutput("t6_reset_pwm", 32'(reset_pwm), 32'(expVec));
      end
      checkOutput("t6_meas0", measOf(0), 4);
      checkOutput("t6_meas1", measOf(1), 7);
      checkOutput("t6_meas2", measOf(2), 2);
      checkOutput("t6_meas3", measOf(3), 9);
      checkOutput("t6_flags", 32'(trip_flag), 0);
      set = '0;
      stepCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
